fetch_unit: RTL and testbench

Instruction-fetch stage that produces the PC/instruction pairs consumed by the IF/ID pipeline register. Holds the program counter, issues word requests to instruction memory over a req/ack handshake, and presents a registered `out_valid`/`out_pc`/`out_inst` triple to the IF/ID stage. Honours downstream `stall` without losing an in-flight instruction, and honours `redirect` (branch/jump) by flushing stale fetches.

---
 rtl/fetch_unit.sv | 131 +++++++++++++
 tb/tb_fetch_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches words over a req/ack port and
// presents registered PC/instruction pairs to IF/ID, with a one-entry skid for stalls.
module fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [INST_W-1:0] imem_rdata,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_pc,
    output logic [INST_W-1:0] out_inst
);

    typedef enum logic [1:0] {IDLE, FETCH, SKID, FLUSH} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;
    logic [INST_W-1:0] skid_inst_q, skid_inst_d;
    logic              out_valid_q, out_valid_d;
    logic [ADDR_W-1:0] out_pc_q, out_pc_d;
    logic [INST_W-1:0] out_inst_q, out_inst_d;

    logic              accept;
    logic [ADDR_W-1:0] redir_pc;

    assign accept   = !out_valid_q || !stall;
    assign redir_pc = {redirect_pc[ADDR_W-1:2], 2'b00};

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_addr_d  = req_addr_q;
        skid_pc_d   = skid_pc_q;
        skid_inst_d = skid_inst_q;
        // A valid output that is not stalled is consumed this cycle.
        out_valid_d = out_valid_q && stall;
        out_pc_d    = out_pc_q;
        out_inst_d  = out_inst_q;
        imem_req    = 1'b0;

        if (redirect) begin
            out_valid_d = 1'b0;
            pc_d        = redir_pc;
        end

        case (state_q)
            IDLE: begin
                state_d    = FETCH;
                req_addr_d = redirect ? redir_pc : pc_q;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (redirect) begin
                    // Without an ack the address must stay put, so drain it in FLUSH.
                    if (imem_ack) req_addr_d = redir_pc;
                    else          state_d    = FLUSH;
                end else if (imem_ack) begin
                    pc_d = pc_q + ADDR_W'(4);
                    if (accept) begin
                        out_valid_d = 1'b1;
                        out_pc_d    = req_addr_q;
                        out_inst_d  = imem_rdata;
                        req_addr_d  = req_addr_q + ADDR_W'(4);
                    end else begin
                        skid_pc_d   = req_addr_q;
                        skid_inst_d = imem_rdata;
                        state_d     = SKID;
                    end
                end
            end
            SKID: begin
                if (redirect) begin
                    req_addr_d = redir_pc;
                    state_d    = FETCH;
                end else if (!stall) begin
                    out_valid_d = 1'b1;
                    out_pc_d    = skid_pc_q;
                    out_inst_d  = skid_inst_q;
                    req_addr_d  = pc_q;
                    state_d     = FETCH;
                end
            end
            FLUSH: begin
                imem_req = 1'b1;
                if (!redirect && imem_ack) begin
                    req_addr_d = pc_q;
                    state_d    = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            req_addr_q  <= RESET_PC;
            skid_pc_q   <= '0;
            skid_inst_q <= '0;
            out_valid_q <= 1'b0;
            out_pc_q    <= '0;
            out_inst_q  <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_addr_q  <= req_addr_d;
            skid_pc_q   <= skid_pc_d;
            skid_inst_q <= skid_inst_d;
            out_valid_q <= out_valid_d;
            out_pc_q    <= out_pc_d;
            out_inst_q  <= out_inst_d;
        end
    end

    assign imem_addr = req_addr_q;
    assign out_valid = out_valid_q;
    assign out_pc    = out_pc_q;
    assign out_inst  = out_inst_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: one DUT at RESET_PC=0x100 with a programmable-wait
// memory, a second at RESET_PC=0xFFFFFFF8 for PC wrap and asynchronous reset.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n, stall, redirect;
    logic [31:0] redirect_pc;
    logic        imem_req, imem_ack, out_valid;
    logic [31:0] imem_addr, imem_rdata, out_pc, out_inst;
    logic [3:0]  wait_cfg, wcnt;

    logic        rst_n_b, stall_b, redirect_b, ack_en_b;
    logic [31:0] redirect_pc_b;
    logic        imem_req_b, imem_ack_b, out_valid_b;
    logic [31:0] imem_addr_b, imem_rdata_b, out_pc_b, out_inst_b;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_unit #(.ADDR_W(32), .INST_W(32), .RESET_PC(32'h0000_0100)) dut_a (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
        .redirect(redirect), .redirect_pc(redirect_pc), .out_valid(out_valid),
        .out_pc(out_pc), .out_inst(out_inst)
    );

    fetch_unit #(.ADDR_W(32), .INST_W(32), .RESET_PC(32'hFFFF_FFF8)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .imem_req(imem_req_b), .imem_addr(imem_addr_b),
        .imem_ack(imem_ack_b), .imem_rdata(imem_rdata_b), .stall(stall_b),
        .redirect(redirect_b), .redirect_pc(redirect_pc_b), .out_valid(out_valid_b),
        .out_pc(out_pc_b), .out_inst(out_inst_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory: acks after the request has been up for wait_cfg cycles.
    always @(posedge clk) begin
        if (!imem_req || imem_ack) wcnt <= 4'd0;
        else                       wcnt <= wcnt + 4'd1;
    end
    assign imem_ack     = imem_req && (wcnt >= wait_cfg);
    assign imem_rdata   = imem_addr ^ 32'hA5A5_A5A5;
    assign imem_ack_b   = imem_req_b && ack_en_b;
    assign imem_rdata_b = imem_addr_b ^ 32'hA5A5_A5A5;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; wait_cfg = 4'd0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        step();
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; wait_cfg = 4'd0;
        #1;
        n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", imem_req); end
        n_tests++; if (imem_addr !== 32'h100) begin n_fail++; $display("FAIL reset_addr: got %h want 00000100", imem_addr); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_tests++; if (out_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", out_pc); end
        n_tests++; if (out_inst !== 32'h0) begin n_fail++; $display("FAIL reset_inst: got %h want 0", out_inst); end
        step();
        rst_n = 1'b1;
        n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL idle_req: got %b want 0", imem_req); end
        step();
        n_tests++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL first_req: got %b want 1", imem_req); end
        n_tests++; if (imem_addr !== 32'h100) begin n_fail++; $display("FAIL first_addr: got %h want 00000100", imem_addr); end
    endtask

    task automatic test_zero_wait();
        logic [31:0] e;
        do_reset();
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            e = 32'h100 + 32'(4 * i);
            n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL zw_valid[%0d]: got %b want 1", i, out_valid); end
            n_tests++; if (out_pc !== e) begin n_fail++; $display("FAIL zw_pc[%0d]: got %h want %h", i, out_pc, e); end
            n_tests++; if (out_inst !== (e ^ 32'hA5A5_A5A5)) begin n_fail++; $display("FAIL zw_inst[%0d]: got %h want %h", i, out_inst, e ^ 32'hA5A5_A5A5); end
        end
    endtask

    task automatic test_delay();
        logic [31:0] ea;
        logic        ev;
        do_reset();
        wait_cfg = 4'd3;
        for (int i = 1; i <= 9; i++) begin
            step();
            ea = (i <= 4) ? 32'h100 : (i <= 8) ? 32'h104 : 32'h108;
            ev = (i == 5) || (i == 9);
            n_tests++; if (imem_addr !== ea) begin n_fail++; $display("FAIL dly_addr[%0d]: got %h want %h", i, imem_addr, ea); end
            n_tests++; if (out_valid !== ev) begin n_fail++; $display("FAIL dly_valid[%0d]: got %b want %b", i, out_valid, ev); end
            if (ev) begin
                n_tests++;
                if (out_pc !== ((i == 5) ? 32'h100 : 32'h104)) begin n_fail++; $display("FAIL dly_pc[%0d]: got %h", i, out_pc); end
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] e;
        do_reset();
        step(); step(); step();
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_tests++; if (out_valid !== 1'b1 || out_pc !== 32'h104) begin n_fail++; $display("FAIL stall_hold[%0d]: got %b/%h want 1/00000104", i, out_valid, out_pc); end
            n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_req[%0d]: got %b want 0", i, imem_req); end
        end
        stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            e = 32'h108 + 32'(4 * i);
            n_tests++; if (out_valid !== 1'b1 || out_pc !== e) begin n_fail++; $display("FAIL stall_after[%0d]: got %b/%h want 1/%h", i, out_valid, out_pc, e); end
            n_tests++; if (out_inst !== (e ^ 32'hA5A5_A5A5)) begin n_fail++; $display("FAIL stall_inst[%0d]: got %h want %h", i, out_inst, e ^ 32'hA5A5_A5A5); end
        end
    endtask

    task automatic test_redirect_fetch();
        do_reset();
        step(); step(); step();
        redirect = 1'b1; redirect_pc = 32'h400;
        step();
        redirect = 1'b0;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rf_valid: got %b want 0", out_valid); end
        n_tests++; if (imem_addr !== 32'h400) begin n_fail++; $display("FAIL rf_addr: got %h want 00000400", imem_addr); end
        step();
        n_tests++; if (out_valid !== 1'b1 || out_pc !== 32'h400) begin n_fail++; $display("FAIL rf_first: got %b/%h want 1/00000400", out_valid, out_pc); end
        step();
        n_tests++; if (out_valid !== 1'b1 || out_pc !== 32'h404) begin n_fail++; $display("FAIL rf_second: got %b/%h want 1/00000404", out_valid, out_pc); end
    endtask

    task automatic test_redirect_flush();
        do_reset();
        step(); step(); step(); step();
        wait_cfg = 4'd5;
        redirect = 1'b1; redirect_pc = 32'h200;
        step();
        redirect = 1'b0;
        for (int i = 5; i <= 9; i++) begin
            n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h10C) begin n_fail++; $display("FAIL fl_addr[%0d]: got %b/%h want 1/0000010c", i, imem_req, imem_addr); end
            n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fl_valid[%0d]: got %b want 0", i, out_valid); end
            step();
        end
        for (int i = 10; i <= 15; i++) begin
            n_tests++; if (imem_addr !== 32'h200) begin n_fail++; $display("FAIL fl_new_addr[%0d]: got %h want 00000200", i, imem_addr); end
            n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fl_drop[%0d]: got %b want 0", i, out_valid); end
            step();
        end
        n_tests++; if (out_valid !== 1'b1 || out_pc !== 32'h200) begin n_fail++; $display("FAIL fl_first: got %b/%h want 1/00000200", out_valid, out_pc); end
        n_tests++; if (out_inst !== 32'hA5A5_A7A5) begin n_fail++; $display("FAIL fl_inst: got %h want a5a5a7a5", out_inst); end
    endtask

    task automatic test_redirect_stall();
        do_reset();
        step(); step(); step();
        stall = 1'b1;
        step();
        n_tests++; if (imem_req !== 1'b0 || out_pc !== 32'h104) begin n_fail++; $display("FAIL rs_skid: got %b/%h want 0/00000104", imem_req, out_pc); end
        redirect = 1'b1; redirect_pc = 32'h303;
        step();
        redirect = 1'b0; stall = 1'b0;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rs_valid: got %b want 0", out_valid); end
        n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h300) begin n_fail++; $display("FAIL rs_addr: got %b/%h want 1/00000300", imem_req, imem_addr); end
        step();
        n_tests++; if (out_valid !== 1'b1 || out_pc !== 32'h300) begin n_fail++; $display("FAIL rs_first: got %b/%h want 1/00000300", out_valid, out_pc); end
        step();
        n_tests++; if (out_valid !== 1'b1 || out_pc !== 32'h304) begin n_fail++; $display("FAIL rs_second: got %b/%h want 1/00000304", out_valid, out_pc); end
    endtask

    task automatic test_wrap();
        logic [31:0] e;
        step();
        ack_en_b = 1'b1;
        rst_n_b  = 1'b1;
        step();
        n_tests++; if (imem_req_b !== 1'b1 || imem_addr_b !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL wrap_req: got %b/%h want 1/fffffff8", imem_req_b, imem_addr_b); end
        for (int i = 0; i < 3; i++) begin
            step();
            e = 32'hFFFF_FFF8 + 32'(4 * i);
            n_tests++; if (out_valid_b !== 1'b1 || out_pc_b !== e) begin n_fail++; $display("FAIL wrap_pc[%0d]: got %b/%h want 1/%h", i, out_valid_b, out_pc_b, e); end
            n_tests++; if (out_inst_b !== (e ^ 32'hA5A5_A5A5)) begin n_fail++; $display("FAIL wrap_inst[%0d]: got %h want %h", i, out_inst_b, e ^ 32'hA5A5_A5A5); end
        end
        ack_en_b = 1'b0;
        #2;
        rst_n_b = 1'b0;
        #1;
        n_tests++; if (imem_req_b !== 1'b0) begin n_fail++; $display("FAIL async_req: got %b want 0", imem_req_b); end
        n_tests++; if (imem_addr_b !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL async_addr: got %h want fffffff8", imem_addr_b); end
        n_tests++; if (out_valid_b !== 1'b0) begin n_fail++; $display("FAIL async_valid: got %b want 0", out_valid_b); end
        n_tests++; if (out_pc_b !== 32'h0 || out_inst_b !== 32'h0) begin n_fail++; $display("FAIL async_data: got %h/%h want 0/0", out_pc_b, out_inst_b); end
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; wait_cfg = 4'd0;
        rst_n_b = 1'b0; stall_b = 1'b0; redirect_b = 1'b0; redirect_pc_b = '0; ack_en_b = 1'b0;
        test_reset();
        test_zero_wait();
        test_delay();
        test_stall();
        test_redirect_fetch();
        test_redirect_flush();
        test_redirect_stall();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
